button_packet_assembler: RTL and testbench
==========================================

// Module: button_packet_assembler
// PURPOSE
//  Front-end stage of the QoS buffer datapath; directly feeds BufferContainer.
//  Debounces the three raw board push-buttons and assembles 4-bit packets MSB-first
//  (high_button = 1, low_button = 0). Each completed packet is presented with a
//  one-cycle valid strobe and a running 12-bit count of packets received.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a button change is accepted
//  PACKET_BITS      4       bits per packet; packet port width
//  COUNT_W          12      width of received_count
// PORTS
//  clock_50        in   1            system clock, 50 MHz; all logic on rising edge
//  reset           in   1            synchronous, active-high reset
//  start           in   1            raw start button, active-low (pressed = 0)
//  high_button     in   1            raw "1" bit button, active-low
//  low_button      in   1            raw "0" bit button, active-low
//  packet          out  PACKET_BITS  last completed packet; held until next completion
//  packet_valid    out  1            one-cycle strobe: packet updated this cycle
//  received_count  out  COUNT_W      number of packets completed since reset
//  bit_count       out  3            bits collected in the current partial packet (0..3)
//  collecting      out  1            1 while FSM in COLLECT
// BEHAVIOUR
//  Reset (reset=1 at clock edge): packet=0, packet_valid=0, received_count=0,
//   bit_count=0, collecting=0, FSM=IDLE, shift reg=0, debounce counters=0,
//   debounced levels=released. Reset wins over every other event in the same cycle.
//  Input conditioning, per button: 2-FF synchronizer, then debouncer. The debounced
//   level changes only after the synchronized level differs from it for
//   DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the counter.
//   press_evt = one-cycle pulse on debounced released->pressed; release makes no event.
//   Latency: raw level stable from edge N -> press_evt high in cycle N+2+DEBOUNCE_CYCLES.
//  FSM (2 states):
//   IDLE:    start_evt -> COLLECT with shift=0, bit_count=0; bit events ignored.
//   COLLECT: start_evt -> abort partial packet; shift=0, bit_count=0; stay COLLECT.
//            high_evt xor low_evt -> shift={shift[2:0],bit}, bit_count+1.
//            high_evt and low_evt in the same cycle -> both dropped, no change.
//            On the 4th accepted bit: next cycle packet={shift[2:0],bit},
//             packet_valid=1, received_count+1, bit_count=0; stay COLLECT.
//            start_evt coinciding with a bit event: start wins, bit dropped.
//  packet_valid is registered; high exactly 1 cycle per packet; never back-to-back
//   (events are separated by >= DEBOUNCE_CYCLES cycles).
//  received_count wraps modulo 2^COUNT_W (4095 -> 0), no saturation.
//  collecting = (FSM == COLLECT); bit_count never reads 4.
//  No backpressure: downstream must accept a packet in its valid cycle.
// TESTING  (DEBOUNCE_CYCLES=4 in all benches)
//  1 Reset, hold all buttons high 20 cycles -> all outputs 0, packet_valid never set.
//  2 Press start, then high,low,high,high (each held 10 cycles, 10 released) ->
//    single packet_valid pulse, packet=4'b1011, received_count=1, bit_count back to 0.
//  3 Bounce: toggle high_button every 2 cycles for 20 cycles, then release ->
//    no bit accepted, bit_count stays 0.
//  4 In COLLECT, 2 bits entered, then start pressed -> bit_count=0; enter 0,0,0,1 ->
//    packet=4'b0001, received_count increments by exactly 1.
//  5 high and low pressed on the same cycle -> no bit accepted; bit presses in IDLE
//    ignored; reset asserted mid-packet -> all outputs 0, FSM IDLE next cycle.
//  6 Force received_count to 4095, complete one packet -> count wraps to 0, valid pulses.

Source files
------------

// File: rtl/button_packet_assembler.sv
// button_packet_assembler: debounces three active-low buttons and assembles MSB-first packets with a valid strobe and running count
module button_packet_assembler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PACKET_BITS = 4,
  parameter int COUNT_W = 12
) (
  input  logic                   clock_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   high_button,
  input  logic                   low_button,
  output logic [PACKET_BITS-1:0] packet,
  output logic                   packet_valid,
  output logic [COUNT_W-1:0]     received_count,
  output logic [2:0]             bit_count,
  output logic                   collecting
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state;
  logic [2:0] raw, sync1, sync2, level, level_d, evt;
  logic [CW-1:0] cnt [3];
  logic [PACKET_BITS-2:0] shift;
  logic bit_evt, new_bit;
  assign raw = {start, high_button, low_button};
  assign bit_evt = evt[1] ^ evt[0];
  assign new_bit = evt[1];
  assign collecting = (state == COLLECT);
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      level <= '1;
      level_d <= '1;
      evt <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      level_d <= level;
      evt <= level_d & ~level;
      for (int i = 0; i < 3; i++)
        if (sync2[i] == level[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level[i] <= sync2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      bit_count <= '0;
      packet <= '0;
      packet_valid <= 1'b0;
      received_count <= '0;
    end else begin
      packet_valid <= 1'b0;
      if (evt[2]) begin
        state <= COLLECT;
        shift <= '0;
        bit_count <= '0;
      end else if (state == COLLECT && bit_evt) begin
        shift <= {shift[PACKET_BITS-3:0], new_bit};
        if (bit_count == 3'(PACKET_BITS - 1)) begin
          packet <= {shift, new_bit};
          packet_valid <= 1'b1;
          received_count <= received_count + 1'b1;
          bit_count <= '0;
        end else bit_count <= bit_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_button_packet_assembler.sv
// tb_button_packet_assembler: directed table-driven bench for button_packet_assembler
module tb_button_packet_assembler;
  logic clock_50 = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b1, high_button = 1'b1, low_button = 1'b1;
  logic [3:0] packet, packet_w;
  logic packet_valid, packet_valid_w;
  logic [11:0] received_count;
  logic [1:0] received_count_w;
  logic [2:0] bit_count, bit_count_w;
  logic collecting, collecting_w;
  int checks = 0, fails = 0, pulses, pulses_w;
  typedef struct {
    logic [2:0] p;
    logic [3:0] pk;
    int pulses;
    int cnt;
    int bc;
    logic coll;
  } vec_t;
  vec_t v[31];

  always #5 clock_50 = ~clock_50;

  button_packet_assembler #(.DEBOUNCE_CYCLES(4), .PACKET_BITS(4), .COUNT_W(12)) dut (
    .clock_50(clock_50), .reset(reset), .start(start), .high_button(high_button),
    .low_button(low_button), .packet(packet), .packet_valid(packet_valid),
    .received_count(received_count), .bit_count(bit_count), .collecting(collecting));

  button_packet_assembler #(.DEBOUNCE_CYCLES(4), .PACKET_BITS(4), .COUNT_W(2)) dut_w (
    .clock_50(clock_50), .reset(reset), .start(start), .high_button(high_button),
    .low_button(low_button), .packet(packet_w), .packet_valid(packet_valid_w),
    .received_count(received_count_w), .bit_count(bit_count_w), .collecting(collecting_w));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic [2:0] p);
    @(posedge clock_50);
    #1;
    {start, high_button, low_button} = ~p;
    if (packet_valid) pulses++;
    if (packet_valid_w) pulses_w++;
  endtask

  task automatic step(input logic [2:0] p);
    pulses = 0;
    pulses_w = 0;
    for (int i = 0; i < 20; i++) cycle(i < 10 ? p : 3'b000);
  endtask

  initial begin
    v[0]  = '{3'b010, 4'h0, 0, 0, 0, 1'b0};
    v[1]  = '{3'b001, 4'h0, 0, 0, 0, 1'b0};
    v[2]  = '{3'b100, 4'h0, 0, 0, 0, 1'b1};
    v[3]  = '{3'b010, 4'h0, 0, 0, 1, 1'b1};
    v[4]  = '{3'b001, 4'h0, 0, 0, 2, 1'b1};
    v[5]  = '{3'b010, 4'h0, 0, 0, 3, 1'b1};
    v[6]  = '{3'b010, 4'hb, 1, 1, 0, 1'b1};
    v[7]  = '{3'b010, 4'hb, 0, 1, 1, 1'b1};
    v[8]  = '{3'b001, 4'hb, 0, 1, 2, 1'b1};
    v[9]  = '{3'b100, 4'hb, 0, 1, 0, 1'b1};
    v[10] = '{3'b001, 4'hb, 0, 1, 1, 1'b1};
    v[11] = '{3'b001, 4'hb, 0, 1, 2, 1'b1};
    v[12] = '{3'b001, 4'hb, 0, 1, 3, 1'b1};
    v[13] = '{3'b010, 4'h1, 1, 2, 0, 1'b1};
    v[14] = '{3'b011, 4'h1, 0, 2, 0, 1'b1};
    v[15] = '{3'b010, 4'h1, 0, 2, 1, 1'b1};
    v[16] = '{3'b011, 4'h1, 0, 2, 1, 1'b1};
    v[17] = '{3'b001, 4'h1, 0, 2, 2, 1'b1};
    v[18] = '{3'b110, 4'h1, 0, 2, 0, 1'b1};
    v[19] = '{3'b010, 4'h1, 0, 2, 1, 1'b1};
    v[20] = '{3'b010, 4'h1, 0, 2, 2, 1'b1};
    v[21] = '{3'b001, 4'h1, 0, 2, 3, 1'b1};
    v[22] = '{3'b001, 4'hc, 1, 3, 0, 1'b1};
    v[23] = '{3'b001, 4'hc, 0, 3, 1, 1'b1};
    v[24] = '{3'b010, 4'hc, 0, 3, 2, 1'b1};
    v[25] = '{3'b010, 4'hc, 0, 3, 3, 1'b1};
    v[26] = '{3'b010, 4'h7, 1, 4, 0, 1'b1};
    v[27] = '{3'b010, 4'h7, 0, 4, 1, 1'b1};
    v[28] = '{3'b010, 4'h7, 0, 4, 2, 1'b1};
    v[29] = '{3'b010, 4'h7, 0, 4, 3, 1'b1};
    v[30] = '{3'b010, 4'hf, 1, 5, 0, 1'b1};

    @(posedge clock_50);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock_50);
    #1 reset = 1'b0;
    pulses = 0;
    pulses_w = 0;
    for (int i = 0; i < 20; i++) cycle(3'b000);
    chk("reset_packet", int'(packet), 0);
    chk("reset_valid_pulses", pulses, 0);
    chk("reset_count", int'(received_count), 0);
    chk("reset_bit_count", int'(bit_count), 0);
    chk("reset_collecting", int'(collecting), 0);

    for (int i = 0; i < 31; i++) begin
      step(v[i].p);
      chk($sformatf("v%0d_packet", i), int'(packet), int'(v[i].pk));
      chk($sformatf("v%0d_valid_cycles", i), pulses, v[i].pulses);
      chk($sformatf("v%0d_count", i), int'(received_count), v[i].cnt);
      chk($sformatf("v%0d_bit_count", i), int'(bit_count), v[i].bc);
      chk($sformatf("v%0d_collecting", i), int'(collecting), int'(v[i].coll));
      chk($sformatf("v%0d_wrap_count", i), int'(received_count_w), v[i].cnt % 4);
      chk($sformatf("v%0d_wrap_valid_cycles", i), pulses_w, v[i].pulses);
    end

    pulses = 0;
    for (int i = 0; i < 20; i++) cycle((i % 4) < 2 ? 3'b010 : 3'b000);
    for (int i = 0; i < 10; i++) cycle(3'b000);
    chk("bounce_bit_count", int'(bit_count), 0);
    chk("bounce_valid_cycles", pulses, 0);
    chk("bounce_collecting", int'(collecting), 1);

    step(3'b010);
    step(3'b001);
    chk("pre_reset_bit_count", int'(bit_count), 2);
    reset = 1'b1;
    @(posedge clock_50);
    #1;
    chk("midreset_packet", int'(packet), 0);
    chk("midreset_valid", int'(packet_valid), 0);
    chk("midreset_count", int'(received_count), 0);
    chk("midreset_bit_count", int'(bit_count), 0);
    chk("midreset_collecting", int'(collecting), 0);
    chk("midreset_wrap_count", int'(received_count_w), 0);
    reset = 1'b0;
    step(3'b010);
    chk("idle_bit_ignored_bc", int'(bit_count), 0);
    chk("idle_bit_ignored_coll", int'(collecting), 0);
    chk("idle_bit_ignored_valid", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
